// File: rtl/main_mem_responder.sv
// Line-granular main memory model for a data cache: accepts one refill or
// writeback at a time and answers after a fixed LATENCY with a held response.
module main_mem_responder #(
   parameter int LATENCY = 4,
   parameter int DEPTH   = 256
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         req_valid_i,
   output logic         req_ready_o,
   input  logic         req_we_i,
   input  logic [31:0]  req_addr_i,
   input  logic [127:0] req_wdata_i,
   output logic         resp_valid_o,
   input  logic         resp_ready_i,
   output logic [127:0] resp_rdata_o,
   output logic         resp_we_o,
   output logic [31:0]  rd_cnt_o,
   output logic [31:0]  wr_cnt_o
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t             state_q, state_d;
   logic [3:0]         cnt_q;
   logic               we_q;
   logic [IDX_W-1:0]   idx_q;
   logic [127:0]       wdata_q;
   logic [127:0]       mem [DEPTH];
   logic               accept, access, done;
   logic               unused_addr;

   assign unused_addr = ^{req_addr_i[31:4+IDX_W], req_addr_i[3:0]};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      req_ready_o  = 1'b0;
      resp_valid_o = 1'b0;
      accept       = 1'b0;
      access       = 1'b0;
      done         = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               accept  = 1'b1;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               access  = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            resp_valid_o = 1'b1;
            if (resp_ready_i) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control: latency counter, response register and completion counters
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q        <= 4'd0;
         resp_rdata_o <= '0;
         resp_we_o    <= 1'b0;
         rd_cnt_o     <= 32'd0;
         wr_cnt_o     <= 32'd0;
      end else begin
         if (accept)
            cnt_q <= 4'(LATENCY - 1);
         else if (state_q == WAIT && cnt_q != 4'd0)
            cnt_q <= cnt_q - 4'd1;
         if (access) begin
            resp_rdata_o <= we_q ? wdata_q : mem[idx_q];
            resp_we_o    <= we_q;
         end
         if (done) begin
            if (resp_we_o) wr_cnt_o <= wr_cnt_o + 32'd1;
            else           rd_cnt_o <= rd_cnt_o + 32'd1;
         end
      end
   end

   // Request payload is captured at acceptance and needs no reset
   always_ff @(posedge clk_i) begin
      if (accept) begin
         we_q    <= req_we_i;
         idx_q   <= req_addr_i[4 +: IDX_W];
         wdata_q <= req_wdata_i;
      end
   end

   // Storage commits only at the access cycle; an aborted WAIT never gets here
   always_ff @(posedge clk_i) begin
      if (access && we_q)
         mem[idx_q] <= wdata_q;
   end

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed bench for main_mem_responder: LATENCY=4 instance for data paths,
// LATENCY=1 instance for back-to-back timing.
module tb_main_mem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         a_req_valid, a_req_ready, a_req_we, a_resp_valid, a_resp_ready, a_resp_we;
   logic [31:0]  a_addr, a_rd, a_wr;
   logic [127:0] a_wdata, a_rdata;
   logic         b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_resp_ready, b_resp_we;
   logic [31:0]  b_addr, b_rd, b_wr;
   logic [127:0] b_wdata, b_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [127:0] D1 = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
   localparam logic [127:0] DA = {4{32'hAAAA_AAAA}};
   localparam logic [127:0] DB = {4{32'hBBBB_BBBB}};
   localparam logic [127:0] DC = {4{32'hCCCC_CCCC}};

   main_mem_responder #(.LATENCY(4), .DEPTH(256)) dut_a (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_we_i(a_req_we),
      .req_addr_i(a_addr), .req_wdata_i(a_wdata),
      .resp_valid_o(a_resp_valid), .resp_ready_i(a_resp_ready),
      .resp_rdata_o(a_rdata), .resp_we_o(a_resp_we),
      .rd_cnt_o(a_rd), .wr_cnt_o(a_wr)
   );

   main_mem_responder #(.LATENCY(1), .DEPTH(256)) dut_b (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_we_i(b_req_we),
      .req_addr_i(b_addr), .req_wdata_i(b_wdata),
      .resp_valid_o(b_resp_valid), .resp_ready_i(b_resp_ready),
      .resp_rdata_o(b_rdata), .resp_we_o(b_resp_we),
      .rd_cnt_o(b_rd), .wr_cnt_o(b_wr)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one request on dut_a; returns at the negedge where resp_valid is seen
   task automatic issue_a(input logic we, input logic [31:0] addr, input logic [127:0] data,
                          input string tag);
      int cyc;
      @(negedge clk);
      chk({tag, "_req_ready"}, 128'(a_req_ready), 128'(1));
      a_req_valid = 1'b1;
      a_req_we    = we;
      a_addr      = addr;
      a_wdata     = data;
      @(negedge clk);
      a_req_valid = 1'b0;
      a_req_we    = 1'b0;
      a_wdata     = '0;
      cyc = 0;
      while (a_resp_valid !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_latency"}, 128'(cyc), 128'(4));
   endtask

   task automatic handshake_a();
      a_resp_ready = 1'b1;
      @(negedge clk);
      a_resp_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      a_req_valid = 1'b0; a_req_we = 1'b0; a_addr = '0; a_wdata = '0; a_resp_ready = 1'b0;
      b_req_valid = 1'b0; b_req_we = 1'b0; b_addr = '0; b_wdata = '0; b_resp_ready = 1'b0;
      #2;
      chk("rst_req_ready",  128'(a_req_ready),  128'(1));
      chk("rst_resp_valid", 128'(a_resp_valid), 128'(0));
      chk("rst_resp_we",    128'(a_resp_we),    128'(0));
      chk("rst_rdata",      a_rdata,            128'(0));
      chk("rst_rd_cnt",     128'(a_rd),         128'(0));
      chk("rst_wr_cnt",     128'(a_wr),         128'(0));
      @(negedge clk);
      rst = 1'b0;

      // LATENCY=1 back-to-back refills with req_valid held high
      @(negedge clk);
      b_resp_ready = 1'b1;
      b_req_valid  = 1'b1;
      b_addr       = 32'h0000_0080;
      @(negedge clk);
      chk("b2b_wait1_valid", 128'(b_resp_valid), 128'(0));
      chk("b2b_wait1_ready", 128'(b_req_ready),  128'(0));
      @(negedge clk);
      chk("b2b_resp1_valid", 128'(b_resp_valid), 128'(1));
      @(negedge clk);
      chk("b2b_idle_ready",  128'(b_req_ready),  128'(1));
      chk("b2b_idle_valid",  128'(b_resp_valid), 128'(0));
      chk("b2b_rd_cnt1",     128'(b_rd),         128'(1));
      @(negedge clk);
      chk("b2b_wait2_ready", 128'(b_req_ready),  128'(0));
      chk("b2b_wait2_valid", 128'(b_resp_valid), 128'(0));
      @(negedge clk);
      chk("b2b_resp2_valid", 128'(b_resp_valid), 128'(1));
      @(negedge clk);
      b_req_valid = 1'b0;
      chk("b2b_rd_cnt2",     128'(b_rd),         128'(2));
      chk("b2b_end_valid",   128'(b_resp_valid), 128'(0));

      // Writeback then refill of the same line, with backpressure on the refill
      issue_a(1'b1, 32'h0000_0040, D1, "wb40");
      chk("wb40_rdata", a_rdata, D1);
      chk("wb40_we",    128'(a_resp_we), 128'(1));
      handshake_a();
      chk("wb40_wr_cnt", 128'(a_wr), 128'(1));
      chk("wb40_rd_cnt", 128'(a_rd), 128'(0));
      chk("wb40_done_valid", 128'(a_resp_valid), 128'(0));

      issue_a(1'b0, 32'h0000_0040, '0, "rf40");
      chk("rf40_we", 128'(a_resp_we), 128'(0));
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid",     128'(a_resp_valid), 128'(1));
         chk("bp_rdata",     a_rdata,            D1);
         chk("bp_req_ready", 128'(a_req_ready),  128'(0));
         chk("bp_rd_cnt",    128'(a_rd),         128'(0));
         @(negedge clk);
      end
      chk("bp_last_valid", 128'(a_resp_valid), 128'(1));
      chk("bp_last_rdata", a_rdata,            D1);
      handshake_a();
      chk("rf40_rd_cnt", 128'(a_rd), 128'(1));
      chk("rf40_wr_cnt", 128'(a_wr), 128'(1));
      @(negedge clk);
      chk("rf40_rd_cnt_once", 128'(a_rd), 128'(1));

      // Aliasing: 0x1010 and 0x0010 share line index 1
      issue_a(1'b1, 32'h0000_1010, DA, "wb1010");
      handshake_a();
      issue_a(1'b0, 32'h0000_0010, '0, "rf10");
      chk("alias_rdata", a_rdata, DA);
      handshake_a();

      // Reset during WAIT of a writeback must not commit the line
      issue_a(1'b1, 32'h0000_0020, DC, "wb20c");
      handshake_a();
      @(negedge clk);
      a_req_valid = 1'b1; a_req_we = 1'b1; a_addr = 32'h0000_0020; a_wdata = DB;
      @(negedge clk);
      a_req_valid = 1'b0; a_req_we = 1'b0; a_wdata = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_valid",  128'(a_resp_valid), 128'(0));
      chk("abort_ready",  128'(a_req_ready),  128'(1));
      chk("abort_wr_cnt", 128'(a_wr),         128'(0));
      @(negedge clk);
      rst = 1'b0;
      issue_a(1'b0, 32'h0000_0020, '0, "rf20");
      chk("abort_rdata", a_rdata, DC);
      handshake_a();
      chk("abort_wr_cnt_after", 128'(a_wr), 128'(0));
      chk("abort_rd_cnt_after", 128'(a_rd), 128'(1));

      // Reset during RESP drops the response without counting it
      issue_a(1'b0, 32'h0000_0040, '0, "rfdrop");
      rst = 1'b1;
      #1;
      chk("drop_valid",  128'(a_resp_valid), 128'(0));
      chk("drop_rd_cnt", 128'(a_rd),         128'(0));
      chk("drop_rdata",  a_rdata,            128'(0));
      @(negedge clk);
      rst = 1'b0;

      // Refill count wraps from all-ones; storage survived the resets
      @(negedge clk);
      force dut_a.rd_cnt_o = 32'hFFFF_FFFF;
      #1;
      release dut_a.rd_cnt_o;
      issue_a(1'b0, 32'h0000_0040, '0, "rfwrap");
      chk("wrap_rdata",  a_rdata,    D1);
      chk("wrap_preset", 128'(a_rd), 128'(32'hFFFF_FFFF));
      handshake_a();
      chk("wrap_rd_cnt", 128'(a_rd), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench time limit reached");
   end

endmodule

// File: doc/main_mem_responder.md
MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 4, meaning cycles from request acceptance to resp_valid_o assertion (legal range 1..15).
REQ-002 The block SHALL have parameter DEPTH, default 256, meaning number of 128-bit lines stored (power of two).
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-high.
REQ-005 req_valid_i  in  1  data cache presents a line request.
REQ-006 req_ready_o  out  1  responder can accept a request this cycle.
REQ-007 req_we_i  in  1  1 = line writeback, 0 = line refill.
REQ-008 req_addr_i  in  32  byte address; bits [3:0] ignored; line index = bits [4+log2(DEPTH)-1:4]; upper bits ignored (aliasing).
REQ-009 req_wdata_i  in  128  writeback line; word 0 in bits [31:0].
REQ-010 resp_valid_o  out  1  response available.
REQ-011 resp_ready_i  in  1  cache accepts the response.
REQ-012 resp_rdata_o  out  128  line read (refill) or line written (writeback echo).
REQ-013 resp_we_o  out  1  copy of the latched req_we_i for the current response.
REQ-014 rd_cnt_o  out  32  completed refills; wraps modulo 2^32.
REQ-015 wr_cnt_o  out  32  completed writebacks; wraps modulo 2^32.

Function
REQ-016 The block SHALL implement FSM states IDLE, WAIT, RESP.
- IDLE: req_ready_o=1, resp_valid_o=0.
- WAIT: both 0.
- RESP: req_ready_o=0, resp_valid_o=1.
REQ-017 A request SHALL be accepted on a cycle with req_valid_i=1 in IDLE. The block SHALL then latch req_we_i, the line index and req_wdata_i, load the latency counter with LATENCY-1, and go to WAIT.
REQ-018 In WAIT the counter SHALL decrement each cycle. When it is 0, the block SHALL perform the access and go to RESP, so resp_valid_o rises exactly LATENCY cycles after the acceptance edge.
REQ-019 Refill access SHALL load resp_rdata_o from the addressed line.
REQ-020 Writeback access SHALL write the latched line into storage and load resp_rdata_o with the same data.
REQ-021 Storage SHALL be updated only at the access cycle, never earlier.
REQ-022 In RESP, resp_valid_o, resp_rdata_o and resp_we_o SHALL hold stable until resp_ready_i=1. On that cycle the block SHALL go to IDLE and increment rd_cnt_o or wr_cnt_o (per resp_we_o) by 1.
REQ-023 Request inputs SHALL be ignored outside IDLE; a request held across RESP->IDLE is accepted on the first IDLE cycle (one idle bubble minimum between responses).
REQ-024 Refill of a line written earlier SHALL return the most recently written data, including a refill issued immediately after the writeback handshake.
REQ-025 Aliased addresses (differing only above the index bits) SHALL map to the same line.
REQ-026 resp_rdata_o SHALL be registered; no combinational path from req_* to resp_*.

Reset
REQ-027 While rst_i=1, independent of clk_i:
- state=IDLE, req_ready_o=1, resp_valid_o=0, resp_we_o=0;
- resp_rdata_o=0, counter=0, rd_cnt_o=0, wr_cnt_o=0.
REQ-028 Reset SHALL NOT modify storage contents.
REQ-029 Reset asserted in WAIT SHALL abort the request: a pending writeback SHALL NOT be committed and no counter SHALL increment.
REQ-030 Reset asserted in RESP SHALL drop the response without counter increment.

Verification
REQ-031 Writeback then refill, LATENCY=4, resp_ready_i=1:
- stimulus: write addr 0x0000_0040, data 0x4444_4444_3333_3333_2222_2222_1111_1111; then read 0x0000_0040.
- response: resp_valid_o high exactly 4 cycles after each acceptance; refill rdata equals the written data; wr_cnt_o=1, rd_cnt_o=1.
REQ-032 Backpressure:
- stimulus: refill completes with resp_ready_i=0 for 5 cycles, then 1.
- response: resp_valid_o high and resp_rdata_o stable all 6 cycles; req_ready_o=0 throughout; rd_cnt_o increments once.
REQ-033 Aliasing, DEPTH=256:
- stimulus: write 0x0000_1010 with data 0xA..A; refill 0x0000_0010.
- response: 0xA..A returned.
REQ-034 Reset mid-writeback:
- stimulus: write 0x20 with data 0xB..B after 0x20 previously held 0xC..C; assert rst_i 2 cycles after acceptance; release; refill 0x20.
- response: 0xC..C returned; wr_cnt_o=0.
REQ-035 LATENCY=1 back-to-back with req_valid_i held high:
- stimulus: two refills.
- response: resp_valid_o the cycle after each acceptance; second acceptance one cycle after first response handshake.
REQ-036 Counter wrap:
- stimulus: force rd_cnt_o to 0xFFFF_FFFF, complete one refill.
- response: rd_cnt_o=0.
